// File: rtl/tbuf_bus_arbiter_pkg.sv
// Shared types and helpers for the TBUF bus arbiter and its round-robin picker.
package tbuf_bus_arbiter_pkg;

  localparam int MAX_N = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  // Owner index width; a 2-requester bus still needs one bit.
  function automatic int owner_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tbuf_bus_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit at or above ptr, wrapping modulo N.
// Pure logic, no state; reusable wherever a rotating-priority pick is needed.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  logic [W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest set bit is the last write.
  always_comb begin
    valid = |req;
    idx   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = W'((int'(ptr) + k) % N);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/tbuf_bus_arbiter.sv
// Round-robin owner arbiter for a shared TBUF readout bus: one-hot registered enables,
// a forced zero turnaround cycle between owners, and a hold limit that preempts long owners.
module tbuf_bus_arbiter
  import tbuf_bus_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int OW       = owner_width(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  done,
  output logic [N-1:0]  grant,
  output logic [OW-1:0] owner,
  output logic          busy,
  output logic          preempt
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  if (N < 2 || N > MAX_N || MAX_HOLD < 1) begin : g_bad_param
    $error("tbuf_bus_arbiter: N must be 2..%0d and MAX_HOLD >= 1", MAX_N);
  end

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [OW-1:0] ptr;

  logic          pick_valid;
  logic [OW-1:0] pick_idx;

  rr_pick #(
    .N (N),
    .W (OW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  logic rel_done;
  logic rel_drop;
  logic rel_limit;

  always_comb begin
    rel_done  = done[owner];
    rel_drop  = ~req[owner];
    rel_limit = (hold_cnt == HW'(MAX_HOLD));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      preempt  <= 1'b0;
      hold_cnt <= '0;
      ptr      <= '0;
    end else begin
      preempt <= 1'b0;
      case (state)
        GRANT: begin
          if (rel_done || rel_drop || rel_limit) begin
            state   <= TURN;
            grant   <= '0;
            busy    <= 1'b0;
            // Only a pure timeout counts as preemption; a voluntary release does not.
            preempt <= rel_limit && !rel_done && !rel_drop;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: begin
          // IDLE and TURN arbitrate identically; TURN exists only to keep grant low one cycle.
          if (pick_valid) begin
            state           <= GRANT;
            grant           <= '0;
            grant[pick_idx] <= 1'b1;
            owner           <= pick_idx;
            busy            <= 1'b1;
            hold_cnt        <= HW'(1);
            ptr             <= (pick_idx == OW'(N - 1)) ? '0 : pick_idx + OW'(1);
          end else begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
// Self-checking bench: directed scenarios plus randomised req/done against an ownership-level model.
module tb_tbuf_bus_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int OW       = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  done;
  logic [N-1:0]  grant;
  logic [OW-1:0] owner;
  logic          busy;
  logic          preempt;

  tbuf_bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .owner   (owner),
    .busy    (busy),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: who holds the bus, for how long, and where the next search starts.
  bit m_busy;
  int m_owner;
  int m_hold;
  int m_ptr;
  bit m_pre;

  task automatic model_step(input bit rst, input logic [N-1:0] r, input logic [N-1:0] d);
    m_pre = 0;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_hold = 0; m_ptr = 0;
    end else if (m_busy) begin
      bit a, b, c;
      a = d[m_owner];
      b = !r[m_owner];
      c = (m_hold == MAX_HOLD);
      if (a || b || c) begin
        m_busy = 0;
        m_pre  = c && !a && !b;
      end else begin
        m_hold++;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int w;
        w = (m_ptr + k) % N;
        if (r[w]) begin
          m_busy = 1; m_owner = w; m_hold = 1; m_ptr = (w + 1) % N;
          break;
        end
      end
    end
  endtask

  logic [N-1:0] prev_grant = '0;
  int run_len = 0;

  task automatic cyc(input bit rst, input logic [N-1:0] r, input logic [N-1:0] d);
    logic [N-1:0] exp_g;
    reset = rst; req = r; done = d;
    @(posedge clk);
    model_step(rst, r, d);
    #1;
    exp_g = m_busy ? (N'(1) << m_owner) : '0;
    chk("grant", grant, exp_g);
    chk("busy", busy, m_busy);
    chk("preempt", preempt, m_pre);
    if (m_busy || rst) chk("owner", owner, m_owner);
    chk("inv_onehot", ($countones(grant) <= 1), 1);
    chk("inv_no_switch", !(prev_grant != 0 && grant != 0 && prev_grant != grant), 1);
    chk("inv_busy", busy, |grant);
    run_len = (grant != 0) ? run_len + 1 : 0;
    chk("inv_hold_len", (run_len <= MAX_HOLD), 1);
    prev_grant = grant;
  endtask

  int starts[$];
  int exp_starts[5] = '{0, 1, 2, 3, 0};

  initial begin
    reset = 1'b1; req = '0; done = '0;

    // Reset state
    cyc(1, 4'b0000, 4'b0000);
    chk("rst_grant", grant, 0);
    chk("rst_owner", owner, 0);
    chk("rst_busy", busy, 0);
    chk("rst_preempt", preempt, 0);

    // Sole requester held: 8 grant cycles, preempt, regrant after one TURN
    for (int k = 1; k <= 10; k++) begin
      cyc(0, 4'b0001, 4'b0000);
      if (k <= 8) chk("hold_grant", grant, 4'b0001);
      if (k == 9) begin
        chk("hold_turn_grant", grant, 0);
        chk("hold_preempt", preempt, 1);
      end
      if (k == 10) chk("hold_regrant", grant, 4'b0001);
    end

    // All requesting, owner releases after 2 cycles: 0,1,2,3,0
    cyc(1, 4'b0000, 4'b0000);
    for (int k = 0; k < 14; k++) begin
      logic [N-1:0] d;
      logic [N-1:0] pg;
      d  = (m_busy && m_hold == 2) ? (N'(1) << m_owner) : '0;
      pg = grant;
      cyc(0, 4'b1111, d);
      chk("rr_no_preempt", preempt, 0);
      if (pg == 0 && grant != 0)
        for (int i = 0; i < N; i++) if (grant[i]) starts.push_back(i);
    end
    chk("rr_count", starts.size(), 5);
    for (int i = 0; i < 5 && i < starts.size(); i++) chk("rr_order", starts[i], exp_starts[i]);

    // Non-owner done ignored; drop of req[2] releases; then idle
    cyc(1, 4'b0000, 4'b0000);
    cyc(0, 4'b0100, 4'b0000);
    chk("own2_grant", grant, 4'b0100);
    cyc(0, 4'b0100, 4'b0001);
    chk("nonowner_done", grant, 4'b0100);
    cyc(0, 4'b0000, 4'b0000);
    chk("drop_release", grant, 0);
    cyc(0, 4'b0000, 4'b0000);
    chk("idle_busy", busy, 0);

    // ptr=3, req=0101 wraps to 0; ptr then 1
    cyc(0, 4'b0101, 4'b0000);
    chk("wrap_win0", grant, 4'b0001);
    cyc(0, 4'b0110, 4'b0000);
    chk("wrap_release", grant, 0);
    cyc(0, 4'b0110, 4'b0000);
    chk("ptr1_win1", grant, 4'b0010);

    // Reset during the 4th grant cycle
    cyc(1, 4'b0000, 4'b0000);
    for (int k = 0; k < 4; k++) cyc(0, 4'b0010, 4'b0000);
    chk("pre_rst_grant", grant, 4'b0010);
    cyc(1, 4'b0010, 4'b0000);
    chk("midrst_grant", grant, 0);
    chk("midrst_owner", owner, 0);
    cyc(0, 4'b0010, 4'b0000);
    chk("post_rst_grant", grant, 4'b0010);

    // Randomised traffic
    begin
      logic [N-1:0] r;
      logic [N-1:0] d;
      r = '0;
      for (int k = 0; k < 4000; k++) begin
        for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
        d = '0;
        for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) d[i] = 1'b1;
        cyc(($urandom_range(0, 499) == 0), r, d);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
